// File: rtl/lane_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_sched_pkg
// Description : Shared constants and types for the lane drain scheduler:
//               lane count, default geometry, mode encoding, score weights.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_sched_pkg;

    localparam int NUM_LANES = 4;
    localparam int DEPTH_DEF = 6;
    localparam int PKT_W_DEF = 3;
    localparam int CNT_W     = 3;   // per-lane occupancy width, limits DEPTH to 7
    localparam int LANE_W    = 2;   // lane index width
    localparam int SCORE_W   = 6;   // max score 6*10 = 60

    localparam logic MODE_LATENCY     = 1'b0;
    localparam logic MODE_RELIABILITY = 1'b1;

    typedef enum logic {
        LATENCY     = MODE_LATENCY,
        RELIABILITY = MODE_RELIABILITY
    } mode_e;

    // Index 0 is lane L1.
    localparam int RS_W [NUM_LANES] = '{1, 2, 3, 4};
    localparam int LS_W [NUM_LANES] = '{4, 3, 2, 1};

endpackage
`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo
// Description : Circular FIFO for one packet lane. Pushes while full and pops
//               while empty are ignored; pointers wrap modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo
    import lane_sched_pkg::*;
#(
    parameter int W      = PKT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int OCC_W  = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     head,
    output logic [OCC_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] c_depth    = OCC_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage array: written on accepted push only, never reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping with wrap at DEPTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + OCC_W'(w_do_push) - OCC_W'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lane_drain_scheduler
// Description : Four packet lanes drained one packet per grant into a single
//               registered valid/ready output. A registered mode (LATENCY /
//               RELIABILITY) derived from weighted occupancy scores RS and LS
//               chooses the tie-break direction of the largest-lane grant.
//               Optional macro LANE_AGING_EN adds per-lane starvation counters
//               that override the mode priority at AGE_LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_drain_scheduler
    import lane_sched_pkg::*;
#(
    parameter int PKT_W     = PKT_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AGE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES-1:0]         in_valid,
    input  logic [NUM_LANES*PKT_W-1:0]   in_data,
    output logic [NUM_LANES-1:0]         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PKT_W-1:0]             out_data,
    output logic [LANE_W-1:0]            out_lane,
    output logic                         mode,
    output logic [NUM_LANES*CNT_W-1:0]   occ,
    output logic [SCORE_W-1:0]           rs,
    output logic [SCORE_W-1:0]           ls
);

    // Occupancy is carried in CNT_W bits, so DEPTH above 7 cannot be represented.
    if (DEPTH < 1 || DEPTH > 7 || AGE_LIMIT < 1) begin : g_cfg_check
        $error("lane_drain_scheduler: DEPTH must be 1..7 and AGE_LIMIT >= 1");
    end

    logic [CNT_W-1:0]     w_cnt  [NUM_LANES];
    logic [PKT_W-1:0]     w_head [NUM_LANES];
    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_pop;
    logic [SCORE_W-1:0]   w_rs;
    logic [SCORE_W-1:0]   w_ls;
    logic [CNT_W-1:0]     w_best;
    logic [LANE_W-1:0]    w_gnt;
    logic                 w_any;
    logic                 w_load;
    mode_e                r_mode;
    logic                 r_out_valid;
    logic [PKT_W-1:0]     r_out_data;
    logic [LANE_W-1:0]    r_out_lane;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        lane_fifo #(
            .W     (PKT_W),
            .DEPTH (DEPTH),
            .OCC_W (CNT_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[gi]),
            .pop   (w_pop[gi]),
            .wdata (in_data[gi*PKT_W +: PKT_W]),
            .head  (w_head[gi]),
            .count (w_cnt[gi]),
            .full  (w_full[gi]),
            .empty (w_empty[gi])
        );
        assign in_ready[gi]               = !w_full[gi];
        assign occ[gi*CNT_W +: CNT_W]     = w_cnt[gi];
        assign w_pop[gi]                  = w_load && w_any && (w_gnt == LANE_W'(gi));
    end

    assign w_load    = !r_out_valid || out_ready;
    assign rs        = w_rs;
    assign ls        = w_ls;
    assign mode      = r_mode;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;

    // Weighted occupancy scores.
    always_comb begin
        w_rs = '0;
        w_ls = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_rs = w_rs + SCORE_W'(RS_W[i]) * SCORE_W'(w_cnt[i]);
            w_ls = w_ls + SCORE_W'(LS_W[i]) * SCORE_W'(w_cnt[i]);
        end
    end

`ifdef LANE_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] c_age_max = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0]     r_age [NUM_LANES];
    logic [NUM_LANES-1:0] w_aged;

    // Starvation counters: count waiting cycles, clear on grant or empty lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_empty[i] || w_pop[i]) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != c_age_max) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    // Lanes that have reached the starvation threshold.
    always_comb begin
        w_aged = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_aged[i] = (r_age[i] == c_age_max) && !w_empty[i];
        end
    end
`endif

    // Grant: largest non-empty lane; equal counts resolve upward in RELIABILITY
    // and downward in LATENCY. A starved lane, when aging exists, wins outright.
    always_comb begin
        w_any  = 1'b0;
        w_best = '0;
        w_gnt  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!w_empty[i]) begin
                if (!w_any || (w_cnt[i] > w_best) ||
                    ((r_mode == RELIABILITY) && (w_cnt[i] == w_best))) begin
                    w_any  = 1'b1;
                    w_best = w_cnt[i];
                    w_gnt  = LANE_W'(i);
                end
            end
        end
`ifdef LANE_AGING_EN
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_aged[i]) begin
                w_gnt = LANE_W'(i);
            end
        end
`endif
    end

    // Mode FSM: follows the score comparison one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= RELIABILITY;
        end else begin
            r_mode <= (w_rs < w_ls) ? LATENCY : RELIABILITY;
        end
    end

    // Output register: refills whenever empty or being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_head[w_gnt];
                r_out_lane <= w_gnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_drain_scheduler
// Description : Self-checking bench for lane_drain_scheduler. A queue-based
//               reference model tracks lanes, mode, output register and ages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_drain_scheduler;

    localparam int PKT_W     = 3;
    localparam int DEPTH     = 6;
    localparam int AGE_LIMIT = 4;
    localparam int NL        = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [11:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_data;
    logic [1:0]  out_lane;
    logic        mode;
    logic [11:0] occ;
    logic [5:0]  rs;
    logic [5:0]  ls;

    lane_drain_scheduler #(
        .PKT_W     (PKT_W),
        .DEPTH     (DEPTH),
        .AGE_LIMIT (AGE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .mode      (mode),
        .occ       (occ),
        .rs        (rs),
        .ls        (ls)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [2:0] q [NL][$];
    logic       m_mode;
    logic       m_ov;
    logic [2:0] m_od;
    logic [1:0] m_ol;
    int         m_age [NL];
    int         last_gnt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            q[i].delete();
            m_age[i] = 0;
        end
        m_mode   = 1'b1;
        m_ov     = 1'b0;
        m_od     = '0;
        m_ol     = '0;
        last_gnt = -1;
    endtask

    // One clock edge of the behavioural rules, using the current inputs.
    task automatic model_edge();
        int  c [NL];
        int  mx;
        int  g;
        int  rs_e;
        int  ls_e;
        bit  load;
        bit  acc [NL];
        mx   = 0;
        g    = -1;
        rs_e = 0;
        ls_e = 0;
        for (int i = 0; i < NL; i++) begin
            c[i] = q[i].size();
            if (c[i] > mx) mx = c[i];
            rs_e += (i + 1) * c[i];
            ls_e += (4 - i) * c[i];
            acc[i] = in_valid[i] && (c[i] < DEPTH);
        end
        load = !m_ov || out_ready;
        if (mx > 0) begin
            if (m_mode == 1'b0) begin
                for (int i = NL - 1; i >= 0; i--) if (c[i] == mx) g = i;
            end else begin
                for (int i = 0; i < NL; i++) if (c[i] == mx) g = i;
            end
`ifdef LANE_AGING_EN
            for (int i = NL - 1; i >= 0; i--) if (m_age[i] == AGE_LIMIT && c[i] > 0) g = i;
`endif
        end
        last_gnt = -1;
        if (load) begin
            if (g >= 0) begin
                m_od     = q[g].pop_front();
                m_ol     = 2'(g);
                m_ov     = 1'b1;
                last_gnt = g;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (c[i] == 0 || last_gnt == i) m_age[i] = 0;
            else if (m_age[i] < AGE_LIMIT)  m_age[i] = m_age[i] + 1;
            if (acc[i]) q[i].push_back(in_data[i*3 +: 3]);
        end
        m_mode = (rs_e < ls_e) ? 1'b0 : 1'b1;
    endtask

    task automatic check_all(string tag);
        logic [11:0] eo;
        logic [3:0]  er;
        int          rs_e;
        int          ls_e;
        rs_e = 0;
        ls_e = 0;
        for (int i = 0; i < NL; i++) begin
            eo[i*3 +: 3] = 3'(q[i].size());
            er[i]        = (q[i].size() < DEPTH);
            rs_e += (i + 1) * q[i].size();
            ls_e += (4 - i) * q[i].size();
        end
        chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, "/out_data"},  32'(out_data),  32'(m_od));
        chk({tag, "/out_lane"},  32'(out_lane),  32'(m_ol));
        chk({tag, "/mode"},      32'(mode),      32'(m_mode));
        chk({tag, "/occ"},       32'(occ),       32'(eo));
        chk({tag, "/in_ready"},  32'(in_ready),  32'(er));
        chk({tag, "/rs"},        32'(rs),        32'(rs_e));
        chk({tag, "/ls"},        32'(ls),        32'(ls_e));
    endtask

    task automatic drive(logic [3:0] v, logic [11:0] d, logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic step(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset applied between edges, checked before any clock.
    task automatic do_reset(string tag);
        drive(4'b0000, 12'h000, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "/rst_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/rst_occ"},       32'(occ),       32'd0);
        chk({tag, "/rst_mode"},      32'(mode),      32'd1);
        chk({tag, "/rst_rs"},        32'(rs),        32'd0);
        chk({tag, "/rst_ls"},        32'(ls),        32'd0);
        chk({tag, "/rst_in_ready"},  32'(in_ready),  32'hF);
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    // Park packet 7 in the output register (stalled), then fill lanes to the
    // requested counts. Lane i packet k carries value 2*i+k+1 (mod 8).
    task automatic preload(string tag, int n0, int n1, int n2, int n3);
        int          n [NL];
        logic [3:0]  v;
        logic [11:0] d;
        n = '{n0, n1, n2, n3};
        do_reset({tag, "_rst"});
        drive(4'b0001, 12'h007, 1'b0);
        step({tag, "_dummy"});
        drive(4'b0000, 12'h000, 1'b0);
        step({tag, "_park"});
        for (int c = 0; c < DEPTH; c++) begin
            v = '0;
            d = '0;
            for (int i = 0; i < NL; i++) begin
                if (c < n[i]) v[i] = 1'b1;
                d[i*3 +: 3] = 3'(2 * i + c + 1);
            end
            if (v != 4'b0000) begin
                drive(v, d, 1'b0);
                step({tag, "_fill"});
            end
        end
        drive(4'b0000, 12'h000, 1'b0);
        step({tag, "_settle"});
        chk({tag, "/parked_data"}, 32'(out_data), 32'd7);
    endtask

    initial begin
        logic [11:0] rd;
        bit          seen;
        int          lanes [4];

        rst = 1'b0;
        do_reset("init");

        // LATENCY: lane 0 holds 3 packets
        preload("lat", 3, 0, 0, 0);
        chk("lat/rs", 32'(rs), 32'd3);
        chk("lat/ls", 32'(ls), 32'd12);
        chk("lat/mode", 32'(mode), 32'd0);
        drive(4'b0000, 12'h000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("lat_drain");
            chk("lat/lane", 32'(out_lane), 32'd0);
            chk("lat/order", 32'(out_data), 32'(k + 1));
        end

        // RELIABILITY: lane 3 x3, lane 0 x1
        preload("rel", 1, 0, 0, 3);
        chk("rel/rs", 32'(rs), 32'd13);
        chk("rel/ls", 32'(ls), 32'd7);
        chk("rel/mode", 32'(mode), 32'd1);
        drive(4'b0000, 12'h000, 1'b1);
        lanes = '{3, 3, 3, 0};
        for (int k = 0; k < 4; k++) begin
            step("rel_drain");
            chk("rel/lane", 32'(out_lane), 32'(lanes[k]));
        end

        // Tie between lanes 0 and 3
        preload("tie03", 2, 0, 0, 2);
        chk("tie03/rs", 32'(rs), 32'd10);
        chk("tie03/ls", 32'(ls), 32'd10);
        chk("tie03/mode", 32'(mode), 32'd1);
        drive(4'b0000, 12'h000, 1'b1);
        step("tie03_grant");
        chk("tie03/lane", 32'(out_lane), 32'd3);

        // Tie between lanes 0 and 1
        preload("tie01", 2, 2, 0, 0);
        chk("tie01/rs", 32'(rs), 32'd6);
        chk("tie01/ls", 32'(ls), 32'd14);
        chk("tie01/mode", 32'(mode), 32'd0);
        drive(4'b0000, 12'h000, 1'b1);
        step("tie01_grant");
        chk("tie01/lane", 32'(out_lane), 32'd0);

        // Full lane and backpressure
        preload("full", 0, 0, 6, 0);
        chk("full/in_ready2", 32'(in_ready[2]), 32'd0);
        chk("full/occ2", 32'(occ[8:6]), 32'd6);
        drive(4'b0100, 12'h1C0, 1'b0);
        step("full_drop");
        chk("full/occ2_drop", 32'(occ[8:6]), 32'd6);
        drive(4'b0000, 12'h000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step("full_stall");
            chk("full/stall_data", 32'(out_data), 32'd7);
        end
        drive(4'b0100, 12'h100, 1'b1);
        step("full_release");
        chk("full/occ2_pop", 32'(occ[8:6]), 32'd5);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 12'(k) << 6, 1'b1);
            step("full_pushpop");
            chk("full/occ2_const", 32'(occ[8:6]), 32'd5);
        end

        // Starvation: lane 0 kept at 5 entries, lane 1 at 1 entry
        preload("age", 5, 1, 0, 0);
        chk("age/mode", 32'(mode), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(4'b0001, 12'(k & 7), 1'b1);
            step("age_run");
`ifdef LANE_AGING_EN
            if (k < 5 && out_lane == 2'd1) seen = 1'b1;
`else
            if (out_lane == 2'd1) seen = 1'b1;
`endif
        end
`ifdef LANE_AGING_EN
        chk("age/lane1_granted", 32'(seen), 32'd1);
`else
        chk("age/lane1_starved", 32'(seen), 32'd0);
`endif

        // Mid-stream asynchronous reset
        chk("mid/out_valid_before", 32'(out_valid), 32'd1);
        do_reset("mid");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            rd = 12'($urandom);
            drive(4'($urandom), rd, ($urandom_range(0, 3) != 0));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
